// File: rtl/swarm_pkg.sv
// Shared types and constants for the monster swarm: FSM state encoding,
// playfield colours and the index-width helper.
package swarm_pkg;

   typedef enum logic [2:0] {
      MARCH_R   = 3'd0,
      DROP_TO_L = 3'd1,
      MARCH_L   = 3'd2,
      DROP_TO_R = 3'd3,
      HALT      = 3'd4
   } swarm_state_e;

   localparam logic [11:0] RED    = 12'hF00;
   localparam logic [11:0] GREEN  = 12'h0F0;
   localparam logic [11:0] BLUE   = 12'h00F;
   localparam logic [11:0] PURPLE = 12'hF0F;
   localparam logic [11:0] BLACK  = 12'h000;

   // Width of an index into n items, never narrower than one bit.
   function automatic int IDX_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/swarm_extent.sv
// Lowest/highest set index and population count of the alive mask.
// lo/hi read 0 when the mask is empty; callers gate on count.
module swarm_extent
   import swarm_pkg::*;
#(
   parameter  int N  = 5,
   localparam int IW = IDX_W(N),
   localparam int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  alive_i,
   output logic [IW-1:0] lo_o,
   output logic [IW-1:0] hi_o,
   output logic [CW-1:0] count_o
);

   // Scan down for the lowest one, up for the highest one, and count.
   always_comb begin
      lo_o    = '0;
      hi_o    = '0;
      count_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (alive_i[i]) lo_o = IW'(i);
      end
      for (int i = 0; i < N; i++) begin
         if (alive_i[i]) hi_o = IW'(i);
         count_o = count_o + CW'(alive_i[i]);
      end
   end

endmodule

// File: rtl/monster_swarm.sv
// N-wide monster row: formation position, alive mask, march/drop FSM and
// per-pixel hit output for the playfield colour mux. Fewer survivors pace
// faster: the row moves once every popcount(alive) steps. Formation x is
// signed because a row whose leftmost survivor sits far right may carry
// base_x below zero while that survivor is still on screen.
module monster_swarm
   import swarm_pkg::*;
#(
   parameter  int          N_MONS  = 5,
   parameter  int          X0      = 250,
   parameter  int          Y0      = 100,
   parameter  int          SPACING = 100,
   parameter  int          HALF_W  = 5,
   parameter  int          HALF_H  = 2,
   parameter  int          STEP_X  = 2,
   parameter  int          STEP_Y  = 8,
   parameter  int          X_MIN   = 150,
   parameter  int          X_MAX   = 780,
   parameter  int          Y_LIMIT = 530,
   parameter  logic [11:0] COLOR   = RED,
   localparam int          IW      = IDX_W(N_MONS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              hit_valid,
   input  logic [IW-1:0]     hit_idx,
   input  logic              bright,
   input  logic [9:0]        hCount,
   input  logic [9:0]        vCount,
   output logic              pix_on,
   output logic [11:0]       pix_rgb,
   output logic [N_MONS-1:0] alive,
   output logic              all_dead,
   output logic              landed,
   output logic [2:0]        dbg_state_o,
   output logic [11:0]       dbg_base_x_o,
   output logic [9:0]        dbg_base_y_o
);

   localparam int CW = $clog2(N_MONS + 1);
   localparam logic signed [13:0] HW_S   = 14'(HALF_W);
   localparam logic signed [13:0] HH_S   = 14'(HALF_H);
   localparam logic signed [13:0] SX_S   = 14'(STEP_X);
   localparam logic signed [13:0] XMIN_S = 14'(X_MIN);
   localparam logic signed [13:0] XMAX_S = 14'(X_MAX);

   swarm_state_e        state_q, state_d;
   logic signed [11:0]  base_x_q, base_x_d;
   logic [9:0]          base_y_q, base_y_d;
   logic [N_MONS-1:0]   alive_q, alive_d;
   logic                all_dead_q, all_dead_d;
   logic                landed_q, landed_d;
   logic [CW-1:0]       pace_q, pace_d;

   logic [IW-1:0]       lo, hi;
   logic [CW-1:0]       count;
   logic                halting, pace_hit, adv, turn_r, turn_l;
   logic                mv_right, mv_left, do_drop, pix_hit;
   logic signed [13:0]  bx, lo_off, hi_off, right_edge, left_edge, px, py, cy;
   logic [10:0]         by_drop, by_bottom;

   swarm_extent #(.N(N_MONS)) u_extent (
      .alive_i (alive_q),
      .lo_o    (lo),
      .hi_o    (hi),
      .count_o (count)
   );

   // Extremes, pacing and edge tests, all from the mask registered this cycle.
   always_comb begin
      bx         = base_x_q;
      lo_off     = 14'(lo) * 14'(SPACING);
      hi_off     = 14'(hi) * 14'(SPACING);
      right_edge = bx + hi_off + HW_S;
      left_edge  = bx + lo_off - HW_S;
      turn_r     = (right_edge + SX_S) > XMAX_S;
      turn_l     = left_edge < (XMIN_S + SX_S);
      halting    = all_dead_q || landed_q || (state_q == HALT);
      pace_hit   = step && ((CW+1)'(pace_q) + (CW+1)'(1) >= (CW+1)'(count));
      adv        = pace_hit && !halting;
      by_drop    = 11'(base_y_q) + 11'(STEP_Y);
      by_bottom  = 11'(base_y_q) + 11'(HALF_H);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= MARCH_R;
      else     state_q <= state_d;
   end

   // FSM next state: a dead or landed row halts ahead of any pending move.
   always_comb begin
      state_d = state_q;
      if (all_dead_q || landed_q) begin
         state_d = HALT;
      end else if (adv) begin
         case (state_q)
            MARCH_R:   if (turn_r) state_d = DROP_TO_L;
            DROP_TO_L: state_d = MARCH_L;
            MARCH_L:   if (turn_l) state_d = DROP_TO_R;
            DROP_TO_R: state_d = MARCH_R;
            default:   state_d = HALT;
         endcase
      end
   end

   // FSM outputs: which movement this pacing step applies.
   always_comb begin
      mv_right = adv && (state_q == MARCH_R) && !turn_r;
      mv_left  = adv && (state_q == MARCH_L) && !turn_l;
      do_drop  = adv && (((state_q == MARCH_R) && turn_r) ||
                         ((state_q == MARCH_L) && turn_l));
   end

   // Datapath next values: movement, pace counter, kills and status flags.
   always_comb begin
      base_x_d = base_x_q;
      base_y_d = base_y_q;
      pace_d   = pace_q;
      alive_d  = alive_q;
      if (mv_right) base_x_d = base_x_q + 12'(STEP_X);
      if (mv_left)  base_x_d = base_x_q - 12'(STEP_X);
      if (do_drop)  base_y_d = (by_drop > 11'd1023) ? 10'd1023 : by_drop[9:0];
      if (step && !halting) pace_d = pace_hit ? '0 : pace_q + CW'(1);
      if (hit_valid && (int'(hit_idx) < N_MONS)) alive_d[hit_idx] = 1'b0;
      all_dead_d = (alive_d == '0);
      landed_d   = landed_q || (by_bottom >= 11'(Y_LIMIT));
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_x_q   <= 12'(X0);
         base_y_q   <= 10'(Y0);
         pace_q     <= '0;
         alive_q    <= '1;
         all_dead_q <= 1'b0;
         landed_q   <= 1'b0;
      end else begin
         base_x_q   <= base_x_d;
         base_y_q   <= base_y_d;
         pace_q     <= pace_d;
         alive_q    <= alive_d;
         all_dead_q <= all_dead_d;
         landed_q   <= landed_d;
      end
   end

   // Pixel test: inclusive boxes around every live monster, no latency.
   always_comb begin
      px      = $signed({4'b0, hCount});
      py      = $signed({4'b0, vCount});
      cy      = $signed({4'b0, base_y_q});
      pix_hit = 1'b0;
      for (int i = 0; i < N_MONS; i++) begin
         if (alive_q[i] &&
             (px >= bx + $signed(14'(i * SPACING)) - HW_S) &&
             (px <= bx + $signed(14'(i * SPACING)) + HW_S) &&
             (py >= cy - HH_S) && (py <= cy + HH_S))
            pix_hit = 1'b1;
      end
      pix_on  = bright && pix_hit;
      pix_rgb = pix_on ? COLOR : BLACK;
   end

   assign alive        = alive_q;
   assign all_dead     = all_dead_q;
   assign landed       = landed_q;
   assign dbg_state_o  = state_q;
   assign dbg_base_x_o = base_x_q;
   assign dbg_base_y_o = base_y_q;

endmodule
